rr_mux_n_reg: RTL and testbench

Parametrised registered N:1 datapath multiplexer with valid/ready handshake. It supersedes the fixed 2:1 5-bit select mux in the KGP-RISC datapath, for example for register-address and write-back source selection.
- Generalised in width and input count.
- Adds a one-entry output register with backpressure.
- Supports two selection modes: an externally driven select, or fair round-robin arbitration among valid inputs.

---
 rtl/rr_mux_n_reg.sv | 125 ++++++++++++
 tb/tb_rr_mux_n_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_n_reg.sv
// Registered N:1 datapath mux with valid/ready handshake and a one-entry output register.
// Channel choice is either an external select (mode=0) or fair round-robin arbitration (mode=1).
module rr_mux_n_reg #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;
    logic             out_valid_q;
    logic [SEL_W-1:0] rr_ptr_q;

    logic             load;
    logic             ext_gnt;
    logic [SEL_W-1:0] ext_idx;
    logic             rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0] rr_ptr_next;

    // The register can take a new word whenever it is empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    // External select: sel values at or beyond NUM_IN match no channel, so never grant.
    always_comb begin
        ext_gnt = 1'b0;
        ext_idx = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                ext_gnt = 1'b1;
                ext_idx = SEL_W'(i);
            end
        end
    end

    // Round-robin: scan from rr_ptr upward with wrap; the first valid channel wins.
    always_comb begin
        int unsigned pos;
        rr_gnt = 1'b0;
        rr_idx = '0;
        pos    = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            pos = 32'(rr_ptr_q) + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            for (int unsigned j = 0; j < NUM_IN; j++) begin
                if (!rr_gnt && pos == j && in_valid[j]) begin
                    rr_gnt = 1'b1;
                    rr_idx = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin
        gnt     = mode ? rr_gnt : ext_gnt;
        gnt_idx = mode ? rr_idx : ext_idx;
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            if (gnt_idx == SEL_W'(j)) begin
                gnt_data = in_data[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        if (gnt_idx == SEL_W'(NUM_IN - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = gnt_idx + SEL_W'(1);
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            in_ready[j] = rst_n && load && gnt && (gnt_idx == SEL_W'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else if (load) begin
            if (gnt) begin
                out_data_q  <= gnt_data;
                out_sel_q   <= gnt_idx;
                out_valid_q <= 1'b1;
                // Pointer only moves on round-robin grants so mode=1 resumes where it left off.
                if (mode) begin
                    rr_ptr_q <= rr_ptr_next;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n_reg.sv
// Directed bench for rr_mux_n_reg: a 4-input instance for most scenarios and a
// 3-input instance for the out-of-range select case.
module tb_rr_mux_n_reg;

    logic        clk;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [19:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [4:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [14:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [4:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    int total;
    int bad;

    rr_mux_n_reg #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_mux_n_reg #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [4:0] d,
                             input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".sel"}, 32'(out_sel), 32'(s));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = 1'b1;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_data3   = '0;
        in_valid3  = '0;
        out_ready3 = 1'b1;

        // Reset held for two edges
        tick();
        tick();
        check_out("reset", 1'b0, 5'd0, 2'd0);
        in_valid = 4'b1111;
        #1;
        check("reset.in_ready", 32'(in_ready), 32'h0);
        check("reset.out_valid3", 32'(out_valid3), 32'h0);

        // Mode 0 basic
        rst_n    = 1'b1;
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b0011;
        in_data[0 +: 5] = 5'b00000;
        in_data[5 +: 5] = 5'b00001;
        #1;
        check("m0.in_ready_sel1", 32'(in_ready), 32'b0010);
        tick();
        check_out("m0.sel1", 1'b1, 5'd1, 2'd1);
        sel = 2'd0;
        #1;
        check("m0.in_ready_sel0", 32'(in_ready), 32'b0001);
        tick();
        check_out("m0.sel0", 1'b1, 5'd0, 2'd0);

        // Round-robin fairness; rr_ptr is still 0 since mode 0 never moves it
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*5 +: 5] = 5'(i + 5);
        #1;
        check("rr.in_ready0", 32'(in_ready), 32'b0001);
        tick(); check_out("rr.c1", 1'b1, 5'd5, 2'd0);
        tick(); check_out("rr.c2", 1'b1, 5'd6, 2'd1);
        tick(); check_out("rr.c3", 1'b1, 5'd7, 2'd2);
        tick(); check_out("rr.c4", 1'b1, 5'd8, 2'd3);
        tick(); check_out("rr.c5", 1'b1, 5'd5, 2'd0);
        tick(); check_out("rr.c6", 1'b1, 5'd6, 2'd1);

        // Grant ch2 to put rr_ptr at 3, then skip invalid ch3 and wrap to ch0
        tick(); check_out("wrap.ch2", 1'b1, 5'd7, 2'd2);
        in_valid = 4'b0101;
        #1;
        check("wrap.in_ready", 32'(in_ready), 32'b0001);
        tick(); check_out("wrap.ch0", 1'b1, 5'd5, 2'd0);
        tick(); check_out("wrap.ch2b", 1'b1, 5'd7, 2'd2);

        // Backpressure with out_data=7 held; rr_ptr is 3
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.in_ready", 32'(in_ready), 32'h0);
            tick();
            check_out("bp.hold", 1'b1, 5'd7, 2'd2);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_in_ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("bp.refill", 1'b1, 5'd8, 2'd3);

        // No valid inputs: register empties, data retained
        in_valid = 4'b0000;
        tick();
        check_out("nogrant", 1'b0, 5'd8, 2'd3);

        // Out-of-range select on the 3-input instance
        in_data3[0 +: 5]  = 5'd3;
        in_data3[5 +: 5]  = 5'd4;
        in_data3[10 +: 5] = 5'd9;
        in_valid3 = 3'b111;
        sel3      = 2'd2;
        #1;
        check("oor.in_ready_sel2", 32'(in_ready3), 32'b100);
        tick();
        check("oor.load_valid", 32'(out_valid3), 32'h1);
        check("oor.load_data", 32'(out_data3), 32'd9);
        sel3 = 2'd3;
        #1;
        check("oor.in_ready_sel3", 32'(in_ready3), 32'h0);
        tick();
        check("oor.valid_drop", 32'(out_valid3), 32'h0);
        check("oor.data_kept", 32'(out_data3), 32'd9);
        check("oor.sel_kept", 32'(out_sel3), 32'd2);

        // Reset mid-operation: load ch1 (rr_ptr -> 2), stall, then reset
        in_valid = 4'b0010;
        tick();
        check_out("midrst.load", 1'b1, 5'd6, 2'd1);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        rst_n     = 1'b0;
        #1;
        check("midrst.in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("midrst.after", 1'b0, 5'd0, 2'd0);
        check("midrst.data3", 32'(out_data3), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("midrst.in_ready_ch0", 32'(in_ready), 32'b0001);
        tick();
        check_out("midrst.first", 1'b1, 5'd5, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
